// File: rtl/job_seq_pkg.sv
// rtl/job_seq_pkg.sv - shared state encoding, default beat counts and counter sizing
package job_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MATW = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int DEF_MAT_BEATS = 1024;
  localparam int DEF_SRC_BEATS = 1024;
  localparam int DEF_DST_BEATS = 32;
  localparam int DEF_FRAME_W   = 16;

  // A single-beat counter still needs one bit of storage.
  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/beat_frame_cnt.sv
// rtl/beat_frame_cnt.sv - modulo-BEATS beat counter with a wrap tick on the final beat
module beat_frame_cnt
  import job_seq_pkg::*;
#(
  parameter int BEATS = DEF_SRC_BEATS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [cnt_w(BEATS)-1:0]   cnt_o,
  output logic                      wrap_o
);

  localparam int W = cnt_w(BEATS);
  localparam logic [W-1:0] LAST = W'(BEATS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = inc_i & (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/job_seq.sv
// rtl/job_seq.sv - job sequencer driving engine matw/run/last and output TLAST from one start
module job_seq
  import job_seq_pkg::*;
#(
  parameter int MAT_BEATS = DEF_MAT_BEATS,
  parameter int SRC_BEATS = DEF_SRC_BEATS,
  parameter int DST_BEATS = DEF_DST_BEATS,
  parameter int FRAME_W   = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_mat,
  input  logic [FRAME_W-1:0] frames,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in_ready,
  input  logic               out_valid,
  input  logic               out_ready,
  output logic               matw,
  output logic               run,
  output logic               last,
  output logic               tlast,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [FRAME_W-1:0] frames_done
);

  localparam int OUT_W = cnt_w(DST_BEATS);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(DST_BEATS - 1);

  state_e state_q, state_d;
  logic [FRAME_W-1:0] frames_q, frames_d;
  logic [FRAME_W-1:0] in_frame_q;
  logic [FRAME_W-1:0] frames_done_q;
  logic [FRAME_W-1:0] frame_last;
  logic               aborted_q, aborted_d;
  logic               job_clr;

  logic                       mat_inc, mat_wrap;
  logic                       in_inc, in_wrap;
  logic                       out_inc, out_wrap;
  logic                       final_beat;
  logic [cnt_w(MAT_BEATS)-1:0] mat_cnt_unused;
  logic [cnt_w(SRC_BEATS)-1:0] in_cnt_unused;
  logic [OUT_W-1:0]            out_cnt;

  // frames_q is non-zero whenever RUN is reachable, so frames-1 never underflows there.
  assign frame_last = frames_q - FRAME_W'(1);

  assign matw        = (state_q == ST_MATW);
  assign run         = (state_q == ST_RUN);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign aborted     = aborted_q;
  assign frames_done = frames_done_q;
  assign last        = run & (in_frame_q >= frame_last);

  assign mat_inc    = matw & in_valid;
  // Beats past the job's last source frame are left uncounted.
  assign in_inc     = run & in_valid & in_ready & (in_frame_q != frames_q);
  assign out_inc    = run & out_valid & out_ready;
  assign tlast      = run & out_valid & (out_cnt == OUT_LAST) & (frames_done_q == frame_last);
  assign final_beat = tlast & out_ready;

  beat_frame_cnt #(.BEATS(MAT_BEATS)) u_mat_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (job_clr),
    .inc_i  (mat_inc),
    .cnt_o  (mat_cnt_unused),
    .wrap_o (mat_wrap)
  );

  beat_frame_cnt #(.BEATS(SRC_BEATS)) u_in_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (job_clr),
    .inc_i  (in_inc),
    .cnt_o  (in_cnt_unused),
    .wrap_o (in_wrap)
  );

  beat_frame_cnt #(.BEATS(DST_BEATS)) u_out_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (job_clr),
    .inc_i  (out_inc),
    .cnt_o  (out_cnt),
    .wrap_o (out_wrap)
  );

  always_comb begin
    state_d   = state_q;
    frames_d  = frames_q;
    aborted_d = 1'b0;
    job_clr   = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            job_clr  = 1'b1;
            frames_d = frames;
            if (load_mat) begin
              state_d = ST_MATW;
            end else if (frames != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_FIN;
            end
          end
        end
        ST_MATW: begin
          if (mat_wrap) begin
            state_d = (frames_q != '0) ? ST_RUN : ST_FIN;
          end
        end
        ST_RUN: begin
          if (final_beat) begin
            state_d = ST_FIN;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      frames_q      <= '0;
      aborted_q     <= 1'b0;
      in_frame_q    <= '0;
      frames_done_q <= '0;
    end else begin
      state_q   <= state_d;
      frames_q  <= frames_d;
      aborted_q <= aborted_d;
      if (job_clr) begin
        in_frame_q <= '0;
      end else if (in_wrap) begin
        in_frame_q <= in_frame_q + FRAME_W'(1);
      end
      if (job_clr) begin
        frames_done_q <= '0;
      end else if (out_wrap) begin
        frames_done_q <= frames_done_q + FRAME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_job_seq.sv
// tb/tb_job_seq.sv - directed self-checking bench for job_seq with a small engine model
module tb_job_seq;

  localparam int MAT = 4;
  localparam int SRC = 8;
  localparam int DST = 2;

  logic clk = 1'b0;
  logic rst_r = 1'b1, start_r = 1'b0, load_mat_r = 1'b0, abort_r = 1'b0;
  logic [15:0] frames_r = '0;
  logic in_valid_r = 1'b0, in_ready_r = 1'b0, out_valid_r = 1'b0, out_ready_r = 1'b0;
  logic matw, run, last, tlast, busy, done, aborted;
  logic [15:0] frames_done;

  int n_tests = 0;
  int n_fail  = 0;

  int matw_cyc, busy_cyc, run_cyc, in_beats, out_beats, tlast_cnt, tlast_beat;
  int done_cnt, aborted_cnt, first_last_in, first_run_cyc, first_last_cyc, fd_bad;
  int run_after_abort, aborted_after_abort, run_at_done;

  always #5 clk = ~clk;

  job_seq #(.MAT_BEATS(MAT), .SRC_BEATS(SRC), .DST_BEATS(DST), .FRAME_W(16)) dut (
    .clk(clk), .rst(rst_r), .start(start_r), .load_mat(load_mat_r), .frames(frames_r),
    .abort(abort_r), .in_valid(in_valid_r), .in_ready(in_ready_r),
    .out_valid(out_valid_r), .out_ready(out_ready_r),
    .matw(matw), .run(run), .last(last), .tlast(tlast), .busy(busy), .done(done),
    .aborted(aborted), .frames_done(frames_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Engine model: outputs for a frame become available once its input frame is in.
  task automatic run_job(input bit lm, input int nfr, input int stall, input int abort_in,
                         input bit abort_final, input int bstart);
    int total, abort_cyc;
    bit fin;
    total = nfr * SRC;
    matw_cyc = 0; busy_cyc = 0; run_cyc = 0; in_beats = 0; out_beats = 0;
    tlast_cnt = 0; tlast_beat = -1; done_cnt = 0; aborted_cnt = 0;
    first_last_in = -1; first_run_cyc = -1; first_last_cyc = -1; fd_bad = 0;
    run_after_abort = -1; aborted_after_abort = -1; run_at_done = -1;
    abort_cyc = -10;
    fin = 1'b0;
    load_mat_r = lm; frames_r = 16'(nfr); start_r = 1'b1;
    step();
    start_r = 1'b0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      in_valid_r  = (in_beats < total) && ($urandom_range(99) >= stall);
      in_ready_r  = ($urandom_range(99) >= stall);
      out_valid_r = (out_beats < (in_beats / SRC) * DST);
      out_ready_r = ($urandom_range(99) >= stall);
      abort_r = 1'b0;
      start_r = 1'b0;
      if (cyc == bstart) begin
        start_r = 1'b1; frames_r = 16'd7; load_mat_r = 1'b1;
      end
      if (abort_in >= 0 && run && in_beats == abort_in && abort_cyc < 0) begin
        abort_r = 1'b1; abort_cyc = cyc;
      end
      if (abort_final && run && out_beats == nfr * DST - 1 && out_valid_r) begin
        out_ready_r = 1'b1; abort_r = 1'b1; abort_cyc = cyc;
      end
      #1;
      if (cyc == abort_cyc + 1) begin
        run_after_abort = int'(run); aborted_after_abort = int'(aborted);
      end
      if (matw) matw_cyc++;
      if (busy) busy_cyc++;
      if (run) run_cyc++;
      if (run && frames_done != 16'(out_beats / DST)) fd_bad++;
      if (run && first_run_cyc < 0) first_run_cyc = cyc;
      if (last && first_last_cyc < 0) first_last_cyc = cyc;
      if (last && first_last_in < 0) first_last_in = in_beats;
      if (run && in_valid_r && in_ready_r) in_beats++;
      if (run && out_valid_r && out_ready_r) out_beats++;
      if (tlast) begin tlast_cnt++; tlast_beat = out_beats; end
      if (done) begin done_cnt++; run_at_done = int'(run); fin = 1'b1; end
      if (aborted) begin aborted_cnt++; fin = 1'b1; end
      step();
    end
    if (!fin) check("job_timeout", 0, 1);
    start_r = 1'b0; abort_r = 1'b0;
    in_valid_r = 1'b0; in_ready_r = 1'b0; out_valid_r = 1'b0; out_ready_r = 1'b0;
  endtask

  initial begin
    rst_r = 1'b1;
    step(); step();
    rst_r = 1'b0;
    #1;
    check("rst_outs", {25'd0, matw, run, last, tlast, busy, done, aborted}, 32'd0);
    check("rst_fd", frames_done, 0);

    // 1: matrix load then two frames
    run_job(1'b1, 2, 0, -1, 1'b0, -1);
    check("t1_matw_cyc", matw_cyc, MAT);
    check("t1_last_in", first_last_in, SRC);
    check("t1_in_beats", in_beats, 2 * SRC);
    check("t1_tlast_cnt", tlast_cnt, 1);
    check("t1_tlast_beat", tlast_beat, 2 * DST);
    check("t1_done", done_cnt, 1);
    check("t1_run_at_done", run_at_done, 0);
    check("t1_fd", frames_done, 2);
    check("t1_fd_track", fd_bad, 0);
    check("t1_idle", busy, 0);

    // 2: single frame, no matrix
    run_job(1'b0, 1, 0, -1, 1'b0, -1);
    check("t2_run_t1", first_run_cyc, 1);
    check("t2_last_t1", first_last_cyc, 1);
    check("t2_matw", matw_cyc, 0);
    check("t2_tlast_cnt", tlast_cnt, 1);
    check("t2_tlast_beat", tlast_beat, DST);
    check("t2_done", done_cnt, 1);
    check("t2_fd", frames_done, 1);

    // 3: zero frames goes straight to FIN
    run_job(1'b0, 0, 0, -1, 1'b0, -1);
    check("t3_busy_cyc", busy_cyc, 1);
    check("t3_run", run_cyc, 0);
    check("t3_matw", matw_cyc, 0);
    check("t3_done", done_cnt, 1);
    check("t3_idle", busy, 0);

    // 4: three frames with handshake stalls
    run_job(1'b0, 3, 30, -1, 1'b0, -1);
    check("t4_in_beats", in_beats, 3 * SRC);
    check("t4_last_in", first_last_in, 2 * SRC);
    check("t4_tlast_cnt", tlast_cnt, 1);
    check("t4_tlast_beat", tlast_beat, 3 * DST);
    check("t4_fd_track", fd_bad, 0);
    check("t4_done", done_cnt, 1);
    check("t4_fd", frames_done, 3);

    // 5: abort after ten input beats, restart two cycles later
    run_job(1'b0, 2, 0, 10, 1'b0, -1);
    check("t5_run_after", run_after_abort, 0);
    check("t5_aborted_after", aborted_after_abort, 1);
    check("t5_done", done_cnt, 0);
    check("t5_fd_partial", frames_done, 1);
    run_job(1'b0, 1, 0, -1, 1'b0, -1);
    check("t5_restart_done", done_cnt, 1);
    check("t5_restart_tlast", tlast_beat, DST);

    // 6a: start while busy has no effect on the running job
    run_job(1'b0, 1, 0, -1, 1'b0, 2);
    check("t6a_matw", matw_cyc, 0);
    check("t6a_tlast_beat", tlast_beat, DST);
    check("t6a_done", done_cnt, 1);
    check("t6a_fd", frames_done, 1);
    check("t6a_idle", busy, 0);

    // 6b: reset during matrix load
    load_mat_r = 1'b1; frames_r = 16'd2; start_r = 1'b1; in_valid_r = 1'b1;
    step();
    start_r = 1'b0;
    check("t6b_matw", matw, 1);
    rst_r = 1'b1;
    step();
    rst_r = 1'b0; in_valid_r = 1'b0;
    check("t6b_outs", {25'd0, matw, run, last, tlast, busy, done, aborted}, 32'd0);
    check("t6b_fd", frames_done, 0);
    step();

    // 6c: abort coincident with the final output beat
    run_job(1'b0, 1, 0, -1, 1'b1, -1);
    check("t6c_aborted", aborted_cnt, 1);
    check("t6c_done", done_cnt, 0);
    check("t6c_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/job_seq.md
Name: job_seq

Overview:
- Hardware job sequencer for the 8-core matrix-vector engine.
- Replaces per-phase software writes of matw/run/last. After one start command it:
  - optionally loads the matrix;
  - streams N source frames through the engine;
  - counts result frames out;
  - generates output TLAST, then reports done.
- Sits between the AXI-Lite register block (start/frames/abort/status) and the engine's matw/run/last inputs. It observes the S_AXIS and M_AXIS handshakes.

Parameters:
- MAT_BEATS, 1024: input beats per matrix load (8 cores x 128 words).
- SRC_BEATS, 1024: accepted input beats per source frame.
- DST_BEATS, 32: output beats per result frame.
- FRAME_W, 16: width of frame counters.

Ports:
- clk  in  1  engine clock (AXIS clock domain).
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle job start pulse.
- load_mat  in  1  sampled at start; 1 = matrix load phase precedes the frames.
- frames  in  FRAME_W  sampled at start; number of source frames in the job.
- abort  in  1  one-cycle pulse that cancels the job.
- in_valid  in  1  S_AXIS_TVALID.
- in_ready  in  1  S_AXIS_TREADY from the engine.
- out_valid  in  1  M_AXIS_TVALID from the engine.
- out_ready  in  1  M_AXIS_TREADY.
- matw  out  1  engine matrix-write enable.
- run  out  1  engine run enable.
- last  out  1  engine last-frame flag.
- tlast  out  1  M_AXIS_TLAST.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at normal job completion.
- aborted  out  1  one-cycle pulse when an abort takes effect.
- frames_done  out  FRAME_W  result frames emitted by the current or last job.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-job returns everything to reset values on the next edge.
- States: IDLE, MATW, RUN, FIN.
- IDLE:
  - On start, latch frames and load_mat and clear frames_done and all counters.
  - Next state is MATW if load_mat=1, else RUN if frames>0, else FIN.
  - start while busy is ignored.
- MATW (matw=1):
  - Counts cycles with in_valid=1. The matrix path has no ready, so in_ready is not used here.
  - On the beat where count = MAT_BEATS-1: next state RUN if frames>0, else FIN. matw drops on the following cycle.
- RUN (run=1):
  - Input beat = in_valid & in_ready.
  - in_beat counts 0..SRC_BEATS-1 and wraps; in_frame increments on the wrap.
  - last=1 from the cycle in_frame reaches frames-1 until leaving RUN. If frames=1, last=1 on RUN entry.
  - Output beat = out_valid & out_ready.
  - out_beat counts 0..DST_BEATS-1 and wraps; frames_done increments on the wrap.
  - tlast is combinational: out_valid & (out_beat==DST_BEATS-1) & (frames_done==frames-1). It is asserted only on the final beat of the job.
  - Input beats after in_frame==frames are not counted. in_ready is the engine's responsibility.
  - When the final output beat is accepted, the next state is FIN.
- FIN: done=1 for one cycle; run and last are 0; then IDLE.
- Abort:
  - In any non-IDLE state: next cycle matw/run/last=0, aborted=1 for one cycle, state IDLE, done not asserted. frames_done holds the partial count.
  - Abort in IDLE is ignored.
  - Abort and start in the same cycle in IDLE: start is ignored.
  - Abort on the same cycle as the final output beat: abort wins, so there is no done pulse.
- Timing: input and output beat counting are independent. Both may occur in the same cycle.
- Width rules: beat counters are clog2(BEATS) bits wide, and each compare uses its own constant. Frame comparisons use frames-1 at FRAME_W bits; frames=0 never reaches these compares.
- Latency: start at cycle t gives busy, matw or run at t+1.

Decomposition:
- Package job_seq_pkg holds:
  - the state enum (IDLE, MATW, RUN, FIN);
  - default beat constants;
  - counter width functions.
- Sub-module beat_frame_cnt:
  - Beat counter with parameter BEATS, increment enable, clear, and wrap tick output.
  - Instantiated for the matrix, input and output paths.

Test Plan:
All directed tests use MAT_BEATS=4, SRC_BEATS=8, DST_BEATS=2.
1. start, load_mat=1, frames=2, all handshakes always high:
   - matw high 4 cycles, then run.
   - last rises after input beat 8.
   - tlast on output beat 4 only.
   - done pulses once; frames_done=2.
2. start, load_mat=0, frames=1:
   - run and last both rise at t+1.
   - Single tlast on output beat 2; done follows; matw never asserted.
3. start, load_mat=0, frames=0: busy for one cycle (FIN), then done. run and matw are never asserted.
4. frames=3 with random in_ready/out_ready stalls:
   - Counters advance only on handshakes.
   - Exactly 24 input beats are counted and tlast occurs once, at output beat 6.
5. abort during RUN after 10 input beats:
   - Next cycle run=0 and aborted=1; done never asserted.
   - A start 2 cycles later is accepted normally.
6. Corner cases:
   - start while busy: ignored, with no counter change.
   - rst during MATW: all outputs 0 on the next cycle.
   - abort in the same cycle as the final output beat: aborted=1, done=0.
